// File: rtl/stepper_pulse_gen_if.sv
`default_nettype none
// ------------------------------------------------------------------------
// stepper_pulse_gen_if: move command / STEP-DIR status bundle, rev 1.0
// ------------------------------------------------------------------------
interface stepper_pulse_gen_if #(
  parameter int STEP_W = 64
) ();
  logic              cmd_valid;
  logic              cmd_ready;
  logic [STEP_W-1:0] steps1;
  logic              dir1;
  logic [STEP_W-1:0] steps2;
  logic              dir2;
  logic              abort;
  logic              step1_out;
  logic              dir1_out;
  logic              step2_out;
  logic              dir2_out;
  logic              busy;
  logic              done;
  logic [STEP_W-1:0] remaining1;
  logic [STEP_W-1:0] remaining2;

  modport master (
    output cmd_valid, steps1, dir1, steps2, dir2, abort,
    input  cmd_ready, step1_out, dir1_out, step2_out, dir2_out,
           busy, done, remaining1, remaining2
  );

  modport slave (
    input  cmd_valid, steps1, dir1, steps2, dir2, abort,
    output cmd_ready, step1_out, dir1_out, step2_out, dir2_out,
           busy, done, remaining1, remaining2
  );
endinterface
`default_nettype wire

// File: rtl/stepper_pulse_gen.sv
`default_nettype none
// ------------------------------------------------------------------------
// stepper_pulse_gen: two-channel STEP/DIR pulse generator, rev 1.0
// ------------------------------------------------------------------------
module stepper_pulse_gen #(
  parameter int STEP_W      = 64,
  parameter int HALF_PERIOD = 25000,
  parameter int DIR_SETUP   = 50
) (
  input  wire logic          clk,
  input  wire logic          reset,
  stepper_pulse_gen_if.slave bus
);

  localparam int TMR_MAX = (HALF_PERIOD > DIR_SETUP) ? HALF_PERIOD : DIR_SETUP;
  localparam int TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;
  localparam logic [TMR_W-1:0]  SETUP_LAST = TMR_W'(DIR_SETUP - 1);
  localparam logic [TMR_W-1:0]  PHASE_LAST = TMR_W'(HALF_PERIOD - 1);
  localparam logic [TMR_W-1:0]  TMR_ONE    = TMR_W'(1);
  localparam logic [STEP_W-1:0] STEP_ONE   = STEP_W'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SETUP = 2'd1,
    S_RUN   = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t            state, state_nx;
  logic [TMR_W-1:0]  timer, timer_nx;
  logic              high_phase, high_phase_nx;
  logic [STEP_W-1:0] rem1, rem1_nx, rem2, rem2_nx;
  logic              step1, step1_nx, step2, step2_nx;
  logic              dir1, dir1_nx, dir2, dir2_nx;
  logic              busy, busy_nx, done, done_nx, ready, ready_nx;
  logic              rem1_nz, rem2_nz;

  assign rem1_nz = |rem1;
  assign rem2_nz = |rem2;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      timer      <= '0;
      high_phase <= 1'b0;
      rem1       <= '0;
      rem2       <= '0;
      step1      <= 1'b0;
      step2      <= 1'b0;
      dir1       <= 1'b0;
      dir2       <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      ready      <= 1'b1;
    end else begin
      state      <= state_nx;
      timer      <= timer_nx;
      high_phase <= high_phase_nx;
      rem1       <= rem1_nx;
      rem2       <= rem2_nx;
      step1      <= step1_nx;
      step2      <= step2_nx;
      dir1       <= dir1_nx;
      dir2       <= dir2_nx;
      busy       <= busy_nx;
      done       <= done_nx;
      ready      <= ready_nx;
    end
  end

  always_comb begin
    state_nx      = state;
    timer_nx      = timer;
    high_phase_nx = high_phase;
    rem1_nx       = rem1;
    rem2_nx       = rem2;
    step1_nx      = step1;
    step2_nx      = step2;
    dir1_nx       = dir1;
    dir2_nx       = dir2;
    busy_nx       = busy;
    done_nx       = 1'b0;
    ready_nx      = ready;

    case (state)
      S_IDLE: begin
        if (bus.cmd_valid) begin
          // A zero/zero command also passes through SETUP for one cycle so
          // that its done strobe lands one cycle after the accept edge.
          state_nx = S_SETUP;
          timer_nx = '0;
          rem1_nx  = bus.steps1;
          rem2_nx  = bus.steps2;
          dir1_nx  = bus.dir1;
          dir2_nx  = bus.dir2;
          busy_nx  = (|bus.steps1) | (|bus.steps2);
          ready_nx = 1'b0;
        end
      end

      S_SETUP: begin
        if (bus.abort || (!rem1_nz && !rem2_nz)) begin
          state_nx = S_DONE;
          done_nx  = 1'b1;
          busy_nx  = 1'b0;
        end else if (timer == SETUP_LAST) begin
          state_nx      = S_RUN;
          timer_nx      = '0;
          high_phase_nx = 1'b1;
          step1_nx      = rem1_nz;
          step2_nx      = rem2_nz;
        end else begin
          timer_nx = timer + TMR_ONE;
        end
      end

      S_RUN: begin
        if (bus.abort) begin
          // Truncated pulses are not counted; remaining shows un-issued steps.
          state_nx      = S_DONE;
          step1_nx      = 1'b0;
          step2_nx      = 1'b0;
          high_phase_nx = 1'b0;
          done_nx       = 1'b1;
          busy_nx       = 1'b0;
        end else if (timer == PHASE_LAST) begin
          timer_nx = '0;
          if (high_phase) begin
            high_phase_nx = 1'b0;
            step1_nx      = 1'b0;
            step2_nx      = 1'b0;
            if (step1) rem1_nx = rem1 - STEP_ONE;
            if (step2) rem2_nx = rem2 - STEP_ONE;
          end else if (!rem1_nz && !rem2_nz) begin
            state_nx = S_DONE;
            done_nx  = 1'b1;
            busy_nx  = 1'b0;
          end else begin
            high_phase_nx = 1'b1;
            step1_nx      = rem1_nz;
            step2_nx      = rem2_nz;
          end
        end else begin
          timer_nx = timer + TMR_ONE;
        end
      end

      S_DONE: begin
        state_nx = S_IDLE;
        ready_nx = 1'b1;
      end

      default: begin
        state_nx = S_IDLE;
      end
    endcase
  end

  assign bus.cmd_ready  = ready;
  assign bus.step1_out  = step1;
  assign bus.dir1_out   = dir1;
  assign bus.step2_out  = step2;
  assign bus.dir2_out   = dir2;
  assign bus.busy       = busy;
  assign bus.done       = done;
  assign bus.remaining1 = rem1;
  assign bus.remaining2 = rem2;

endmodule
`default_nettype wire
